// File: rtl/obstacle_ctrl.sv
// Obstacle scheduler: three left-scrolling slots, LFSR-driven spawner and sticky dino hit flag.
// Optional macro OBSTACLE_SPEEDUP_EN raises the scroll speed by 1 px every 512 frames.
module obstacle_ctrl #(
  parameter int unsigned H_BASE     = 144,
  parameter int unsigned V_BASE     = 35,
  parameter int unsigned SPAWN_X    = H_BASE + 490,
  parameter int unsigned LANE_Y0    = V_BASE + 80,
  parameter int unsigned LANE_Y1    = V_BASE + 200,
  parameter int unsigned LANE_Y2    = V_BASE + 320,
  parameter int unsigned OBJ_SIZE   = 100,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned MAX_SPEED  = 12,
  parameter int unsigned FIRST_GAP  = 60,
  parameter int unsigned MIN_GAP    = 40,
  parameter int unsigned HIT_MARGIN = 8
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       run,
  input  logic [9:0] dinoX,
  input  logic [9:0] dinoY,
  output logic [9:0] picX1,
  output logic [9:0] picX2,
  output logic [9:0] picX3,
  output logic [9:0] picY1,
  output logic [9:0] picY2,
  output logic [9:0] picY3,
  output logic       mode1,
  output logic       mode2,
  output logic       mode3,
  output logic       enable1,
  output logic       enable2,
  output logic       enable3,
  output logic       collision
);

  localparam int unsigned CW    = 10;
  localparam int unsigned WW    = 11;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned SPD_W = $clog2(MAX_SPEED + 1);
  localparam int unsigned NSLOT = 3;

  logic [CW-1:0]    pic_x_q [NSLOT];
  logic [CW-1:0]    pic_x_d [NSLOT];
  logic [CW-1:0]    pic_y_q [NSLOT];
  logic [CW-1:0]    pic_y_d [NSLOT];
  logic [NSLOT-1:0] en_q, en_d;
  logic [NSLOT-1:0] mode_q, mode_d;
  logic             coll_q, coll_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [SPD_W-1:0] speed_c;
  logic             tick_c, adv_c;
  logic [NSLOT-1:0] slot_hit_c;
  logic [CW-1:0]    lane_y_c;
  logic             spawned_c;

  assign tick_c = (h_count == 10'd799) && (v_count == 10'd524);
  assign adv_c  = tick_c && run && !coll_q;

  // Shrunken-hitbox overlap test, 11 bits wide so the sums cannot wrap
  always_comb begin
    slot_hit_c = '0;
    for (int n = 0; n < NSLOT; n++) begin
      slot_hit_c[n] = en_q[n]
        && ((WW'(pic_x_q[n]) + WW'(HIT_MARGIN)) < (WW'(dinoX) + WW'(OBJ_SIZE)))
        && ((WW'(dinoX) + WW'(HIT_MARGIN)) < (WW'(pic_x_q[n]) + WW'(OBJ_SIZE)))
        && ((WW'(pic_y_q[n]) + WW'(HIT_MARGIN)) < (WW'(dinoY) + WW'(OBJ_SIZE)))
        && ((WW'(dinoY) + WW'(HIT_MARGIN)) < (WW'(pic_y_q[n]) + WW'(OBJ_SIZE)));
    end
  end

  always_comb begin
    lane_y_c = CW'(LANE_Y1);
    case (lfsr_q[1:0])
      2'd0:    lane_y_c = CW'(LANE_Y0);
      2'd2:    lane_y_c = CW'(LANE_Y2);
      default: lane_y_c = CW'(LANE_Y1);
    endcase
  end

  // Per-frame update: a hit freezes the field; otherwise move/retire, then spawn into a pre-tick free slot
  always_comb begin
    pic_x_d   = pic_x_q;
    pic_y_d   = pic_y_q;
    en_d      = en_q;
    mode_d    = mode_q;
    coll_d    = coll_q;
    gap_d     = gap_q;
    lfsr_d    = lfsr_q;
    spawned_c = 1'b0;
    if (adv_c) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (|slot_hit_c) begin
        coll_d = 1'b1;
      end else begin
        for (int n = 0; n < NSLOT; n++) begin
          if (en_q[n]) begin
            if (WW'(pic_x_q[n]) >= (WW'(H_BASE) + WW'(speed_c))) begin
              pic_x_d[n] = pic_x_q[n] - CW'(speed_c);
            end else begin
              en_d[n] = 1'b0;
            end
          end
        end
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          for (int n = 0; n < NSLOT; n++) begin
            if (!en_q[n] && !spawned_c) begin
              spawned_c  = 1'b1;
              pic_x_d[n] = CW'(SPAWN_X);
              pic_y_d[n] = lane_y_c;
              mode_d[n]  = lfsr_q[2];
              en_d[n]    = 1'b1;
              gap_d      = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[5:0]);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      for (int n = 0; n < NSLOT; n++) begin
        pic_x_q[n] <= CW'(SPAWN_X);
        pic_y_q[n] <= CW'(LANE_Y0);
      end
      en_q   <= '0;
      mode_q <= '0;
      coll_q <= 1'b0;
      gap_q  <= GAP_W'(FIRST_GAP);
      lfsr_q <= 16'hACE1;
    end else begin
      pic_x_q <= pic_x_d;
      pic_y_q <= pic_y_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      coll_q  <= coll_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  logic [8:0]       frame_q, frame_d;
  logic [SPD_W-1:0] speed_q, speed_d;

  // Speed steps up on each 512-frame wrap, capped at MAX_SPEED
  always_comb begin
    frame_d = frame_q;
    speed_d = speed_q;
    if (adv_c) begin
      frame_d = frame_q + 9'd1;
      if ((&frame_q) && (speed_q < SPD_W'(MAX_SPEED))) begin
        speed_d = speed_q + SPD_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      frame_q <= '0;
      speed_q <= SPD_W'(SPEED);
    end else begin
      frame_q <= frame_d;
      speed_q <= speed_d;
    end
  end

  assign speed_c = speed_q;
`else
  assign speed_c = SPD_W'(SPEED);
`endif

  assign picX1     = pic_x_q[0];
  assign picX2     = pic_x_q[1];
  assign picX3     = pic_x_q[2];
  assign picY1     = pic_y_q[0];
  assign picY2     = pic_y_q[1];
  assign picY3     = pic_y_q[2];
  assign mode1     = mode_q[0];
  assign mode2     = mode_q[1];
  assign mode3     = mode_q[2];
  assign enable1   = en_q[0];
  assign enable2   = en_q[1];
  assign enable3   = en_q[2];
  assign collision = coll_q;

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Testbench for obstacle_ctrl: hit-geometry vector table, hand-written frame sequences,
// and randomized frames checked against a behavioural model of the obstacle field.
module tb_obstacle_ctrl;

  localparam int H_BASE = 144;
  localparam int SPAWN_X = 634;
  localparam int SIZE = 100;
  localparam int MARGIN = 8;
  localparam int MIN_GAP = 40;
  localparam int FIRST_GAP = 2;

  logic       vga_clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] h_count = '0, v_count = '0;
  logic       run = 1'b1;
  logic [9:0] dinoX = '0, dinoY = '0;
  logic [9:0] picX1, picX2, picX3, picY1, picY2, picY3;
  logic       mode1, mode2, mode3, enable1, enable2, enable3, collision;

  obstacle_ctrl #(.FIRST_GAP(FIRST_GAP)) dut (
    .vga_clk(vga_clk), .rst(rst), .h_count(h_count), .v_count(v_count), .run(run),
    .dinoX(dinoX), .dinoY(dinoY),
    .picX1(picX1), .picX2(picX2), .picX3(picX3),
    .picY1(picY1), .picY2(picY2), .picY3(picY3),
    .mode1(mode1), .mode2(mode2), .mode3(mode3),
    .enable1(enable1), .enable2(enable2), .enable3(enable3),
    .collision(collision)
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model of the obstacle field
  int m_x[3], m_y[3], m_mode[3], m_en[3];
  int m_coll, m_gap, m_speed, m_frame;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    int   taps[4];
    logic b;
    taps = '{16, 14, 13, 11};
    b = 1'b0;
    foreach (taps[i]) b = b ^ s[taps[i]-1];
    return {s[14:0], b};
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      m_x[n] = SPAWN_X; m_y[n] = 115; m_mode[n] = 0; m_en[n] = 0;
    end
    m_coll = 0; m_gap = FIRST_GAP; m_speed = 4; m_frame = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_tick(int dx, int dy, bit r);
    int  lanes[4];
    int  was_en[3];
    bit  hit;
    int  free;
    if (!r || m_coll != 0) return;
    lanes = '{115, 235, 355, 235};
    hit = 0;
    for (int n = 0; n < 3; n++) begin
      was_en[n] = m_en[n];
      if (m_en[n] != 0 && m_x[n] + MARGIN < dx + SIZE && dx + MARGIN < m_x[n] + SIZE &&
          m_y[n] + MARGIN < dy + SIZE && dy + MARGIN < m_y[n] + SIZE) hit = 1;
    end
    if (hit) begin
      m_coll = 1;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (was_en[n] != 0) begin
          if (m_x[n] - m_speed >= H_BASE) m_x[n] -= m_speed;
          else m_en[n] = 0;
        end
      end
      if (m_gap > 0) begin
        m_gap--;
      end else begin
        free = -1;
        for (int n = 0; n < 3; n++) if (was_en[n] == 0 && free < 0) free = n;
        if (free >= 0) begin
          m_x[free] = SPAWN_X;
          m_y[free] = lanes[int'(m_lfsr) % 4];
          m_mode[free] = (int'(m_lfsr) >> 2) & 1;
          m_en[free] = 1;
          m_gap = MIN_GAP + (int'(m_lfsr) & 63);
        end
      end
    end
`ifdef OBSTACLE_SPEEDUP_EN
    m_frame = (m_frame + 1) % 512;
    if (m_frame == 0 && m_speed < 12) m_speed++;
`endif
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic compare_all(string tag);
    int dx[3], dy[3], dm[3], de[3];
    dx = '{int'(picX1), int'(picX2), int'(picX3)};
    dy = '{int'(picY1), int'(picY2), int'(picY3)};
    dm = '{int'(mode1), int'(mode2), int'(mode3)};
    de = '{int'(enable1), int'(enable2), int'(enable3)};
    for (int n = 0; n < 3; n++) begin
      check($sformatf("%s enable%0d", tag, n + 1), de[n], m_en[n]);
      check($sformatf("%s picX%0d", tag, n + 1), dx[n], m_x[n]);
      check($sformatf("%s picY%0d", tag, n + 1), dy[n], m_y[n]);
      check($sformatf("%s mode%0d", tag, n + 1), dm[n], m_mode[n]);
    end
    check($sformatf("%s collision", tag), int'(collision), m_coll);
  endtask

  // All drive/sample happens at negedge; one tick spans exactly one posedge
  task automatic do_reset();
    rst = 1'b1;
    h_count = 10'($urandom_range(0, 798));
    v_count = 10'($urandom_range(0, 524));
    @(negedge vga_clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_tick(int dx, int dy, bit r);
    dinoX = 10'(dx); dinoY = 10'(dy); run = r;
    h_count = 10'd799; v_count = 10'd524;
    @(negedge vga_clk);
    h_count = 10'($urandom_range(0, 798));
    v_count = 10'($urandom_range(0, 524));
    model_tick(dx, dy, r);
  endtask

  task automatic idle_cycle();
    h_count = 10'($urandom_range(0, 798));
    v_count = 10'($urandom_range(0, 524));
    @(negedge vga_clk);
  endtask

  typedef struct {
    bit run;
    int dx;
    int dy;
    int exp_coll;
    int exp_en1;
    int exp_x1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int x_snap, e_snap;
    // Single lane-1 slot at x=634 (after 3 ticks), probed at hitbox edges
    tbl[0] = '{1'b1, 542, 235, 0, 1, 630};
    tbl[1] = '{1'b1, 543, 235, 1, 1, 634};
    tbl[2] = '{1'b1, 725, 235, 1, 1, 634};
    tbl[3] = '{1'b1, 726, 235, 0, 1, 630};
    tbl[4] = '{1'b1, 634, 143, 0, 1, 630};
    tbl[5] = '{1'b1, 634, 144, 1, 1, 634};
    tbl[6] = '{1'b1, 634, 326, 1, 1, 634};
    tbl[7] = '{1'b1, 634, 327, 0, 1, 630};
    tbl[8] = '{1'b0, 634, 235, 0, 1, 634};

    @(negedge vga_clk);

    // Reset state and first spawn
    do_reset();
    check("reset enable1", int'(enable1), 0);
    check("reset picX2", int'(picX2), 634);
    check("reset picY3", int'(picY3), 115);
    check("reset mode1", int'(mode1), 0);
    check("reset collision", int'(collision), 0);
    do_tick(0, 0, 1'b1);
    check("tick1 enable1", int'(enable1), 0);
    do_tick(0, 0, 1'b1);
    check("tick2 enable1", int'(enable1), 0);
    do_tick(0, 0, 1'b1);
    check("tick3 enable1", int'(enable1), 1);
    check("tick3 picX1", int'(picX1), 634);
    check("tick3 picY1", int'(picY1), 235);
    check("tick3 mode1", int'(mode1), 1);
    do_tick(0, 0, 1'b1);
    check("tick4 picX1", int'(picX1), 630);
    check("tick4 enable2", int'(enable2), 0);

    // Hitbox boundary table
    foreach (tbl[i]) begin
      do_reset();
      repeat (3) do_tick(0, 0, 1'b1);
      check($sformatf("vec%0d pre collision", i), int'(collision), 0);
      do_tick(tbl[i].dx, tbl[i].dy, tbl[i].run);
      check($sformatf("vec%0d collision", i), int'(collision), tbl[i].exp_coll);
      check($sformatf("vec%0d enable1", i), int'(enable1), tbl[i].exp_en1);
      check($sformatf("vec%0d picX1", i), int'(picX1), tbl[i].exp_x1);
    end

    // Sticky collision: frozen field, run toggling does not clear, reset does
    do_reset();
    repeat (3) do_tick(0, 0, 1'b1);
    do_tick(634, 235, 1'b1);
    check("sticky set", int'(collision), 1);
    for (int k = 0; k < 6; k++) do_tick(0, 0, k[0]);
    check("sticky held", int'(collision), 1);
    check("sticky picX1 frozen", int'(picX1), 634);
    check("sticky enable2 frozen", int'(enable2), 0);
    do_reset();
    check("sticky cleared by rst", int'(collision), 0);
    check("sticky rst enable1", int'(enable1), 0);

    // Retire at the left edge without underflow
    do_reset();
    repeat (3 + 121) do_tick(0, 0, 1'b1);
    check("edge picX1 150", int'(picX1), 150);
    do_tick(0, 0, 1'b1);
    check("edge picX1 146", int'(picX1), 146);
    check("edge enable1 still on", int'(enable1), 1);
    do_tick(0, 0, 1'b1);
    check("edge retired enable1", int'(enable1), 0);
    check("edge retired picX1 held", int'(picX1), 146);
    compare_all("edge");

    // run=0 freezes everything across 10 ticks; mid-line reset
    do_reset();
    repeat (8) do_tick(0, 0, 1'b1);
    x_snap = int'(picX1); e_snap = int'(enable1);
    repeat (10) do_tick(0, 0, 1'b0);
    check("freeze picX1", int'(picX1), x_snap);
    check("freeze enable1", int'(enable1), e_snap);
    repeat (60) do_tick(0, 0, 1'b1);
    compare_all("after freeze");
    rst = 1'b1; h_count = 10'd400; v_count = 10'd100;
    @(negedge vga_clk);
    rst = 1'b0;
    model_reset();
    compare_all("midline rst");

    // Randomized frames against the model
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      compare_all("rand reset");
      for (int t = 0; t < 400; t++) begin
        int dx, dy;
        bit r;
        r = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 99) < 3) begin
          dx = $urandom_range(144, 700); dy = $urandom_range(0, 420);
        end else begin
          dx = 0; dy = 0;
        end
        repeat ($urandom_range(0, 2)) idle_cycle();
        do_tick(dx, dy, r);
        compare_all($sformatf("rand ep%0d t%0d", ep, t));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
